fpu_unpack_sequencer: RTL and testbench

//  Time-multiplexes one shared FP operand unpacker across the X, Y and Z operands of an FPU op.

---
 rtl/fpu_unpack_sequencer_pkg.sv | 40 ++++
 rtl/fpu_unpack_sequencer_if.sv | 38 +++
 rtl/fpu_unpack_sequencer.sv | 105 ++++++++++
 tb/tb_fpu_unpack_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_unpack_sequencer_pkg.sv
// Shared FPU unpack types: unpacked operand slot, sequencer states, flag indices.
// Format widths are package-wide so the slot struct is identical in every user.
package fpu_unpack_sequencer_pkg;
  localparam int FLEN    = 64;
  localparam int NE      = 11;
  localparam int NF      = 52;
  localparam int FMTBITS = 2;
  localparam int NFLAGS  = 6;
  localparam int OPW     = 1 + NE + NF + 1 + NFLAGS + FLEN;

  localparam int FLG_NAN     = 0;
  localparam int FLG_SNAN    = 1;
  localparam int FLG_ZERO    = 2;
  localparam int FLG_INF     = 3;
  localparam int FLG_EXPMAX  = 4;
  localparam int FLG_SUBNORM = 5;

  localparam logic [FMTBITS-1:0] FMT_S = 2'b00;
  localparam logic [FMTBITS-1:0] FMT_D = 2'b01;
  localparam logic [FMTBITS-1:0] FMT_H = 2'b10;
  localparam logic [FMTBITS-1:0] FMT_Q = 2'b11;

  typedef enum logic [2:0] {ST_IDLE, ST_OPX, ST_OPY, ST_OPZ, ST_DONE} unpk_state_t;

  typedef struct packed {
    logic              sgn;
    logic [NE-1:0]     exp;
    logic [NF:0]       man;
    logic [NFLAGS-1:0] flags;
    logic [FLEN-1:0]   postbox;
  } unpacked_op_t;

  // First operand state among the still-pending enables {Z,Y,X}.
  function automatic unpk_state_t first_op(input logic [2:0] en);
    if (en[0])      return ST_OPX;
    else if (en[1]) return ST_OPY;
    else if (en[2]) return ST_OPZ;
    else            return ST_DONE;
  endfunction
endpackage

// File: rtl/fpu_unpack_sequencer_if.sv
// Request / shared-unpacker / response bundle of the operand unpack sequencer.
interface fpu_unpack_sequencer_if;
  import fpu_unpack_sequencer_pkg::*;

  logic               Flush;
  logic               ReqValid;
  logic               ReqReady;
  logic [FLEN-1:0]    ReqX;
  logic [FLEN-1:0]    ReqY;
  logic [FLEN-1:0]    ReqZ;
  logic [FMTBITS-1:0] ReqFmt;
  logic [2:0]         ReqEn;

  logic [FLEN-1:0]    UnpkA;
  logic               UnpkEn;
  logic [FMTBITS-1:0] UnpkFmt;
  logic               UnpkSgn;
  logic [NE-1:0]      UnpkExp;
  logic [NF:0]        UnpkMan;
  logic [NFLAGS-1:0]  UnpkFlags;
  logic [FLEN-1:0]    UnpkPostBox;

  logic               RspValid;
  logic               RspReady;
  logic [3*OPW-1:0]   RspOp;

  modport slave (
    input  Flush, ReqValid, ReqX, ReqY, ReqZ, ReqFmt, ReqEn,
    input  UnpkSgn, UnpkExp, UnpkMan, UnpkFlags, UnpkPostBox, RspReady,
    output ReqReady, UnpkA, UnpkEn, UnpkFmt, RspValid, RspOp
  );

  modport master (
    output Flush, ReqValid, ReqX, ReqY, ReqZ, ReqFmt, ReqEn,
    output UnpkSgn, UnpkExp, UnpkMan, UnpkFlags, UnpkPostBox, RspReady,
    input  ReqReady, UnpkA, UnpkEn, UnpkFmt, RspValid, RspOp
  );
endinterface

// File: rtl/fpu_unpack_sequencer.sv
// Walks one shared combinational unpacker over the enabled X/Y/Z operands of a
// latched request and presents the three unpacked slots as a single response.
module fpu_unpack_sequencer
  import fpu_unpack_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  fpu_unpack_sequencer_if.slave bus
);

  unpk_state_t        state, state_nxt;
  logic               rsp_vld_q, rsp_vld_nxt;
  logic [FLEN-1:0]    x_q, y_q, z_q;
  logic [FMTBITS-1:0] fmt_q;
  logic [2:0]         en_q;
  unpacked_op_t [2:0] slot_q;

  logic         in_op;
  logic         rsp_take;
  logic         accept;
  unpacked_op_t unpk_res;

  assign in_op    = (state == ST_OPX) || (state == ST_OPY) || (state == ST_OPZ);
  assign rsp_take = rsp_vld_q & bus.RspReady;
  assign bus.ReqReady = (state == ST_IDLE) || ((state == ST_DONE) && rsp_take);
  assign accept   = bus.ReqValid & bus.ReqReady;

  assign unpk_res = {bus.UnpkSgn, bus.UnpkExp, bus.UnpkMan, bus.UnpkFlags, bus.UnpkPostBox};

  // Unpacker inputs stay at zero outside operand cycles so it never toggles idle.
  always_comb begin
    bus.UnpkA = '0;
    unique case (state)
      ST_OPX:  bus.UnpkA = x_q;
      ST_OPY:  bus.UnpkA = y_q;
      ST_OPZ:  bus.UnpkA = z_q;
      default: bus.UnpkA = '0;
    endcase
  end

  assign bus.UnpkEn   = in_op;
  assign bus.UnpkFmt  = in_op ? fmt_q : '0;
  assign bus.RspValid = rsp_vld_q;
  assign bus.RspOp    = slot_q;

  always_comb begin
    state_nxt   = state;
    rsp_vld_nxt = rsp_vld_q;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = first_op(bus.ReqEn);
      ST_OPX:  state_nxt = first_op(en_q & 3'b110);
      ST_OPY:  state_nxt = first_op(en_q & 3'b100);
      ST_OPZ:  state_nxt = ST_DONE;
      ST_DONE: begin
        // An empty request spends one cycle here before its response shows.
        if (!rsp_vld_q) begin
          rsp_vld_nxt = 1'b1;
        end else if (rsp_take) begin
          rsp_vld_nxt = 1'b0;
          state_nxt   = accept ? first_op(bus.ReqEn) : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (in_op && (state_nxt == ST_DONE)) rsp_vld_nxt = 1'b1;
    if (bus.Flush) begin
      state_nxt   = ST_IDLE;
      rsp_vld_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rsp_vld_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      fmt_q     <= '0;
      en_q      <= '0;
      slot_q    <= '0;
    end else begin
      state     <= state_nxt;
      rsp_vld_q <= rsp_vld_nxt;
      if (!bus.Flush) begin
        if (accept) begin
          x_q    <= bus.ReqX;
          y_q    <= bus.ReqY;
          z_q    <= bus.ReqZ;
          fmt_q  <= bus.ReqFmt;
          en_q   <= bus.ReqEn;
          slot_q <= '0;
        end else begin
          unique case (state)
            ST_OPX:  slot_q[0] <= unpk_res;
            ST_OPY:  slot_q[1] <= unpk_res;
            ST_OPZ:  slot_q[2] <= unpk_res;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_unpack_sequencer.sv
// Bench for fpu_unpack_sequencer: behavioural unpacker on the Unpk* ports, a
// per-cycle request/response model, and directed vectors with literal checks.
module tb_fpu_unpack_sequencer;
  import fpu_unpack_sequencer_pkg::*;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   en_cnt = 0;

  fpu_unpack_sequencer_if bus();

  fpu_unpack_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // IEEE unpack of an S/H/D operand (Q treated as D), exponent rebiased to double.
  function automatic unpacked_op_t unpack(input logic [63:0] a, input logic [1:0] fmt);
    unpacked_op_t r;
    int ew, fw, w;
    logic [63:0] v, e, f, emax, ones;
    r = '0;
    if (fmt == FMT_S)      begin ew = 8;  fw = 23; end
    else if (fmt == FMT_H) begin ew = 5;  fw = 10; end
    else                   begin ew = 11; fw = 52; end
    w = 1 + ew + fw;
    ones = ~64'd0;
    emax = (64'd1 << ew) - 64'd1;
    v = a;
    if (w < 64 && (a >> w) != (ones >> w))
      v = (ones << w) | (emax << fw) | (64'd1 << (fw - 1));
    e = (v >> fw) & emax;
    f = v & ((64'd1 << fw) - 64'd1);
    r.postbox = v;
    r.sgn = v[w-1];
    r.flags[FLG_SUBNORM] = (e == 0) && (f != 0);
    r.flags[FLG_EXPMAX]  = (e == emax);
    r.flags[FLG_INF]     = (e == emax) && (f == 0);
    r.flags[FLG_ZERO]    = (e == 0) && (f == 0);
    r.flags[FLG_NAN]     = (e == emax) && (f != 0);
    r.flags[FLG_SNAN]    = (e == emax) && (f != 0) && !f[fw-1];
    if (e == 0)         r.exp = '0;
    else if (e == emax) r.exp = '1;
    else                r.exp = 11'(e + 64'd1023 - (emax >> 1));
    r.man = 53'(((e != 0) ? (64'd1 << 52) : 64'd0) | (f << (52 - fw)));
    return r;
  endfunction

  unpacked_op_t unpk_out;
  assign unpk_out        = unpack(bus.UnpkA, bus.UnpkFmt);
  assign bus.UnpkSgn     = unpk_out.sgn;
  assign bus.UnpkExp     = unpk_out.exp;
  assign bus.UnpkMan     = unpk_out.man;
  assign bus.UnpkFlags   = unpk_out.flags;
  assign bus.UnpkPostBox = unpk_out.postbox;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Model: pending operands in drive order, cycles left until the response, response value.
  logic [63:0]      mq[$];
  logic [1:0]       mfmt;
  int               mleft;
  logic             mvld;
  logic [3*OPW-1:0] mrsp;

  initial begin
    mq.delete(); mleft = 0; mvld = 1'b0; mrsp = '0; mfmt = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mq.delete(); mleft = 0; mvld = 1'b0;
        check("rst_rspvalid", bus.RspValid, 1'b0);
        check("rst_unpken",   bus.UnpkEn, 1'b0);
        check("rst_unpka",    bus.UnpkA, 64'd0);
        check("rst_unpkfmt",  bus.UnpkFmt, 2'd0);
        check("rst_rspop",    bus.RspOp, '0);
      end else begin
        logic exp_rdy;
        exp_rdy = (mleft == 0 && !mvld) || (mvld && bus.RspReady);
        check("reqready", bus.ReqReady, exp_rdy);
        check("rspvalid", bus.RspValid, mvld);
        check("unpken", bus.UnpkEn, mq.size() > 0);
        check("unpka", bus.UnpkA, (mq.size() > 0) ? mq[0] : 64'd0);
        if (mq.size() > 0) check("unpkfmt", bus.UnpkFmt, mfmt);
        if (mvld) check("rspop", bus.RspOp, mrsp);
        if (bus.UnpkEn) en_cnt++;
        if (bus.Flush) begin
          mq.delete(); mleft = 0; mvld = 1'b0;
        end else begin
          if (mleft > 0) begin
            if (mq.size() > 0) void'(mq.pop_front());
            mleft--;
            if (mleft == 0) mvld = 1'b1;
          end else if (mvld && bus.RspReady) begin
            mvld = 1'b0;
          end
          if (bus.ReqValid && exp_rdy) begin
            logic [63:0] ops[3];
            ops[0] = bus.ReqX; ops[1] = bus.ReqY; ops[2] = bus.ReqZ;
            mq.delete();
            mfmt = bus.ReqFmt;
            for (int k = 0; k < 3; k++) begin
              mrsp[k*OPW +: OPW] = bus.ReqEn[k] ? unpack(ops[k], bus.ReqFmt) : '0;
              if (bus.ReqEn[k]) mq.push_back(ops[k]);
            end
            mleft = (mq.size() > 0) ? mq.size() : 1;
            mvld = 1'b0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic unpacked_op_t slot(input int k);
    return bus.RspOp[k*OPW +: OPW];
  endfunction

  task automatic set_req(input logic [63:0] x, y, z, input logic [1:0] fmt, input logic [2:0] en);
    bus.ReqX = x; bus.ReqY = y; bus.ReqZ = z; bus.ReqFmt = fmt; bus.ReqEn = en;
    bus.ReqValid = 1'b1;
  endtask

  // Holds the request until accepted, then counts cycles to RspValid.
  task automatic do_req(input logic [63:0] x, y, z, input logic [1:0] fmt, input logic [2:0] en,
                        output int lat);
    int n;
    set_req(x, y, z, fmt, en);
    n = 0;
    while (!bus.ReqReady && n < 50) begin step(); n++; end
    check("accept_wait", bus.ReqReady, 1'b1);
    en_cnt = 0;
    step();
    bus.ReqValid = 1'b0;
    lat = 0;
    while (!bus.RspValid && lat < 20) begin step(); lat++; end
    if (lat == 0) lat = 0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin step(); lat++; end while (!bus.RspValid && lat < 20);
  endtask

  task automatic take_rsp();
    bus.RspReady = 1'b1;
    step();
    bus.RspReady = 1'b0;
  endtask

  initial begin
    int lat;
    unpacked_op_t s;
    logic [3*OPW-1:0] held;
    reset_n = 1'b0;
    bus.Flush = 1'b0; bus.ReqValid = 1'b0; bus.RspReady = 1'b0;
    bus.ReqX = '0; bus.ReqY = '0; bus.ReqZ = '0; bus.ReqFmt = '0; bus.ReqEn = '0;
    step(); step();
    check("rst_reqready", bus.ReqReady, 1'b1);
    reset_n = 1'b1;
    step();

    // D 1.0 on X only
    set_req(64'h3FF0000000000000, 64'h0, 64'h0, FMT_D, 3'b001);
    en_cnt = 0; step(); bus.ReqValid = 1'b0;
    wait_rsp(lat);
    check("d1_lat", lat, 1);
    s = slot(0);
    check("d1_exp", s.exp, 11'h3FF);
    check("d1_man", s.man, 53'h10000000000000);
    check("d1_flags", s.flags, 6'd0);
    check("d1_yz", bus.RspOp[3*OPW-1:OPW], '0);
    take_rsp();

    // S, all three enabled
    set_req(64'hFFFFFFFF3F800000, 64'hFFFFFFFF00000001, 64'hFFFFFFFF7F800000, FMT_S, 3'b111);
    en_cnt = 0; step(); bus.ReqValid = 1'b0;
    wait_rsp(lat);
    check("s3_lat", lat, 3);
    check("s3_unpken_cycles", en_cnt, 3);
    s = slot(0); check("s3_x_exp", s.exp, 11'h3FF);
    s = slot(1); check("s3_y_subnorm", s.flags[FLG_SUBNORM], 1'b1);
    s = slot(2); check("s3_z_inf", s.flags[FLG_INF], 1'b1);
    take_rsp();

    // Improperly NaN-boxed single
    set_req(64'h000000003F800000, 64'h0, 64'h0, FMT_S, 3'b001);
    step(); bus.ReqValid = 1'b0;
    wait_rsp(lat);
    s = slot(0);
    check("box_nan", s.flags[FLG_NAN], 1'b1);
    check("box_snan", s.flags[FLG_SNAN], 1'b0);
    check("box_sgn", s.sgn, 1'b0);
    check("box_postbox", s.postbox, 64'hFFFFFFFF7FC00000);
    take_rsp();

    // Half 1.0 on Z only
    set_req(64'h0, 64'h0, 64'hFFFFFFFFFFFF3C00, FMT_H, 3'b100);
    step(); bus.ReqValid = 1'b0;
    wait_rsp(lat);
    s = slot(2);
    check("h1_lat", lat, 1);
    check("h1_exp", s.exp, 11'h3FF);
    take_rsp();

    // No operands enabled
    set_req(64'h1234, 64'h5678, 64'h9ABC, FMT_D, 3'b000);
    en_cnt = 0; step(); bus.ReqValid = 1'b0;
    wait_rsp(lat);
    check("en0_lat", lat, 1);
    check("en0_rspop", bus.RspOp, '0);
    check("en0_unpken", en_cnt, 0);
    take_rsp();

    // Back-to-back with a 5-cycle response stall
    set_req(64'hC000000000000000, 64'h0000000000000001, 64'h0, FMT_D, 3'b011);
    step();
    set_req(64'h0, 64'h0, 64'hFFFFFFFF7F800001, FMT_S, 3'b100);
    wait_rsp(lat);
    check("b2b_a_lat", lat, 2);
    held = bus.RspOp;
    for (int i = 0; i < 5; i++) begin
      check("stall_reqready", bus.ReqReady, 1'b0);
      check("stall_rspop", bus.RspOp, held);
      step();
    end
    bus.RspReady = 1'b1;
    #1;
    check("b2b_reqready", bus.ReqReady, 1'b1);
    step();
    bus.RspReady = 1'b0; bus.ReqValid = 1'b0;
    wait_rsp(lat);
    check("b2b_b_lat", lat, 1);
    s = slot(2);
    check("b2b_b_snan", s.flags[FLG_SNAN], 1'b1);
    take_rsp();

    // Flush while driving Y
    set_req(64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000, FMT_D, 3'b111);
    step(); bus.ReqValid = 1'b0;
    step();
    bus.Flush = 1'b1;
    step();
    bus.Flush = 1'b0;
    check("flush_idle", bus.ReqReady, 1'b1);
    check("flush_rspvalid", bus.RspValid, 1'b0);
    step(); step();
    check("flush_quiet", bus.RspValid, 1'b0);
    do_req(64'h0, 64'hBFF0000000000000, 64'h0, FMT_D, 3'b010, lat);
    check("flush_next_lat", lat, 1);
    s = slot(1);
    check("flush_next_sgn", s.sgn, 1'b1);
    check("flush_next_x", bus.RspOp[OPW-1:0], '0);
    take_rsp();

    // Reset pulse while driving Y
    set_req(64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000, FMT_D, 3'b111);
    step(); bus.ReqValid = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    check("rst_mid_unpken", bus.UnpkEn, 1'b0);
    check("rst_mid_rspvalid", bus.RspValid, 1'b0);
    step(); step();
    reset_n = 1'b1;
    step();
    check("rst_mid_quiet", bus.RspValid, 1'b0);
    do_req(64'h0, 64'h0, 64'h8000000000000000, FMT_D, 3'b100, lat);
    check("rst_next_lat", lat, 1);
    s = slot(2);
    check("rst_next_zero", s.flags[FLG_ZERO], 1'b1);
    take_rsp();
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
